// File: rtl/hcnt_timing_decoder_if.sv
// Horizontal-count link between the H8-feedback counter and its timing decoder.
// The generator drives hcnt/h8; the decoder returns line timing and lock status.
interface hcnt_timing_decoder_if;
   logic [7:0] hcnt;
   logic       h8;
   logic       hblank;
   logic       hsync;
   logic       line_start;
   logic       locked;
   logic [7:0] err_cnt;

   modport master (output hcnt, h8, input hblank, hsync, line_start, locked, err_cnt);
   modport slave  (input hcnt, h8, output hblank, hsync, line_start, locked, err_cnt);
endinterface

// File: rtl/hcnt_timing_decoder.sv
// Checks the incoming horizontal count against a local flywheel, tracks lock,
// and decodes registered HBLANK/HSYNC/line-start from the flywheel position.
module hcnt_timing_decoder #(
   parameter logic [7:0] LOAD_VAL   = 8'hC0,
   parameter int         HBL_START  = 0,
   parameter int         HBL_END    = 64,
   parameter int         HS_START   = 16,
   parameter int         HS_END     = 40,
   parameter int         LOCK_LINES = 2,
   parameter int         MAX_MISS   = 3
) (
   input logic                 clk,
   input logic                 rst,
   hcnt_timing_decoder_if.slave bus
);
   localparam int         LINE_LEN = 512 - int'(LOAD_VAL);
   localparam logic [8:0] LAST_POS = 9'(LINE_LEN - 1);
   localparam logic [8:0] SEG0_OFS = 9'(256 - int'(LOAD_VAL));

   typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} state_t;

   state_t     state;
   logic [7:0] hcnt_r;
   logic       h8_r;
   logic [8:0] in_pos, fly_pos, fly_cur, fly_nxt, cmp_pos;
   logic       in_pos_valid, acquire, match, cmp_lock;
   logic [7:0] line_cnt, miss_cnt, err_cnt;
   logic       hblank, hsync, line_start, locked;
   logic       dec_hbl, dec_hs, dec_ls;
   int         p;

   always_comb begin
      if (h8_r) begin
         in_pos       = {1'b0, hcnt_r} - {1'b0, LOAD_VAL};
         in_pos_valid = (hcnt_r >= LOAD_VAL);
      end else begin
         in_pos       = {1'b0, hcnt_r} + SEG0_OFS;
         in_pos_valid = 1'b1;
      end
   end

   // On acquisition the current compare is treated as position 0.
   assign acquire = (state == UNLOCKED) && in_pos_valid && (in_pos == 9'd0);
   assign fly_cur = acquire ? 9'd0 : fly_pos;
   assign fly_nxt = (fly_cur == LAST_POS) ? 9'd0 : fly_cur + 9'd1;
   assign match   = in_pos_valid && (in_pos == fly_pos);

   always_comb begin
      p       = int'(cmp_pos);
      dec_hbl = (p >= HBL_START) && (p < HBL_END);
      dec_hs  = (p >= HS_START) && (p < HS_END);
      dec_ls  = (p == 0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= UNLOCKED;
         hcnt_r     <= 8'd0;
         h8_r       <= 1'b0;
         fly_pos    <= 9'd0;
         cmp_pos    <= 9'd0;
         cmp_lock   <= 1'b0;
         line_cnt   <= 8'd0;
         miss_cnt   <= 8'd0;
         err_cnt    <= 8'd0;
         hblank     <= 1'b1;
         hsync      <= 1'b0;
         line_start <= 1'b0;
         locked     <= 1'b0;
      end else begin
         hcnt_r   <= bus.hcnt;
         h8_r     <= bus.h8;
         fly_pos  <= fly_nxt;
         cmp_pos  <= fly_cur;
         cmp_lock <= 1'b0;
         case (state)
            UNLOCKED: begin
               if (acquire) begin
                  state    <= TRACK;
                  line_cnt <= 8'd0;
               end
            end
            TRACK: begin
               // A mismatch beats a coincident line-count completion.
               if (!match) begin
                  state <= UNLOCKED;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               end else if (fly_pos == 9'd0) begin
                  line_cnt <= line_cnt + 8'd1;
                  if (line_cnt + 8'd1 == 8'(LOCK_LINES)) begin
                     state    <= LOCKED;
                     miss_cnt <= 8'd0;
                     cmp_lock <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               cmp_lock <= 1'b1;
               if (!match) begin
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  if (miss_cnt + 8'd1 == 8'(MAX_MISS)) begin
                     state    <= UNLOCKED;
                     miss_cnt <= 8'd0;
                     cmp_lock <= 1'b0;
                  end else begin
                     miss_cnt <= miss_cnt + 8'd1;
                  end
               end else begin
                  miss_cnt <= 8'd0;
               end
            end
            default: state <= UNLOCKED;
         endcase
         // Output stage: decode of the previous compare position and lock.
         hblank     <= cmp_lock ? dec_hbl : 1'b1;
         hsync      <= cmp_lock && dec_hs;
         line_start <= cmp_lock && dec_ls;
         locked     <= cmp_lock;
      end
   end

   assign bus.hblank     = hblank;
   assign bus.hsync      = hsync;
   assign bus.line_start = line_start;
   assign bus.locked     = locked;
   assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_hcnt_timing_decoder.sv
// Self-checking bench for hcnt_timing_decoder: reference model feeds a
// scoreboard, plus scenario checks on lock timing and error counting.
module tb_hcnt_timing_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   hcnt_timing_decoder_if bus();
   hcnt_timing_decoder dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {logic hb; logic hs; logic ls; logic lk;} out_t;
   out_t       q_out[$];
   logic [7:0] q_err[$];
   int checks = 0, failures = 0;
   int m_st, m_fly, m_line, m_miss, m_err;
   int spos, k;

   task automatic model_reset();
      m_st = 0; m_fly = 0; m_line = 0; m_miss = 0; m_err = 0;
      q_out.delete(); q_err.delete(); k = 0;
   endtask

   // Reference behaviour for one sample; st: 0 unlocked, 1 track, 2 locked.
   task automatic model_step(input logic h, input logic [7:0] c);
      int pos, cur; bit valid, lk; out_t o;
      valid = !(h && c < 8'hC0);
      pos = h ? int'(c) - 192 : int'(c) + 64;
      cur = m_fly;
      if (m_st == 0) begin
         if (valid && pos == 0) begin m_st = 1; m_line = 0; cur = 0; end
      end else if (!valid || pos != cur) begin
         if (m_err < 255) m_err++;
         if (m_st == 1) m_st = 0;
         else begin
            m_miss++;
            if (m_miss == 3) begin m_st = 0; m_miss = 0; end
         end
      end else if (m_st == 2) m_miss = 0;
      else if (cur == 0) begin
         m_line++;
         if (m_line == 2) begin m_st = 2; m_miss = 0; end
      end
      lk = (m_st == 2);
      o.lk = lk; o.hb = lk ? (cur < 64) : 1'b1;
      o.hs = lk && cur >= 16 && cur < 40; o.ls = lk && cur == 0;
      m_fly = (cur + 1) % 320;
      q_out.push_back(o); q_err.push_back(8'(m_err));
   endtask

   task automatic step(input logic h, input logic [7:0] c);
      out_t o, a; logic [7:0] e;
      bus.h8 = h; bus.hcnt = c;
      @(posedge clk); k++;
      model_step(h, c);
      @(negedge clk);
      if (q_err.size() > 1) begin
         e = q_err.pop_front(); checks++;
         if (bus.err_cnt !== e) begin
            failures++; $display("FAIL sb_err k=%0d got=%0d exp=%0d", k, bus.err_cnt, e);
         end
      end
      if (q_out.size() > 2) begin
         o = q_out.pop_front(); a = {bus.hblank, bus.hsync, bus.line_start, bus.locked};
         checks++;
         if (a !== o) begin
            failures++; $display("FAIL sb_out k=%0d got=%b exp=%b (hb,hs,ls,lk)", k, a, o);
         end
      end
   endtask

   task automatic pos_step();
      logic h; logic [7:0] c;
      h = (spos < 64);
      c = h ? 8'(192 + spos) : 8'(spos - 64);
      spos = (spos + 1) % 320;
      step(h, c);
   endtask

   task automatic run(input int n);
      repeat (n) pos_step();
   endtask

   task automatic run_to(input int target);
      while (k < target) pos_step();
   endtask

   // Reset for one clock with the stream still presented; that sample is lost.
   task automatic do_reset();
      bus.h8 = (spos < 64);
      bus.hcnt = (spos < 64) ? 8'(192 + spos) : 8'(spos - 64);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      spos = (spos + 1) % 320;
      model_reset();
   endtask

   task automatic chk_lock(input string nm, input logic exp);
      checks++;
      if (bus.locked !== exp) begin
         failures++; $display("FAIL %s locked=%b exp=%b k=%0d", nm, bus.locked, exp, k);
      end
   endtask

   task automatic chk_err(input string nm, input logic [7:0] exp);
      checks++;
      if (bus.err_cnt !== exp) begin
         failures++; $display("FAIL %s err_cnt=%0d exp=%0d", nm, bus.err_cnt, exp);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      checks++;
      if ({bus.hblank, bus.hsync, bus.line_start, bus.locked} !== 4'b1000 || bus.err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL %s hb,hs,ls,lk=%b%b%b%b err=%0d exp=1000 err=0", nm,
                  bus.hblank, bus.hsync, bus.line_start, bus.locked, bus.err_cnt);
      end
   endtask

   task automatic lock_up();
      spos = 0; do_reset(); spos = 0;
      run(643);
      chk_lock("lock_up", 1'b1);
   endtask

   task automatic test_reset();
      spos = 0; do_reset();
      chk_reset_vals("reset_vals");
   endtask

   task automatic test_clean();
      int nls, nhb, nhs;
      spos = 0; do_reset(); spos = 0;
      run(642); chk_lock("clean_pre_lock", 1'b0);
      run(1);   chk_lock("clean_lock", 1'b1);
      nls = 0; nhb = 0; nhs = 0;
      for (int i = 0; i < 320; i++) begin
         if (i > 0) pos_step();
         nls += int'(bus.line_start); nhb += int'(bus.hblank); nhs += int'(bus.hsync);
      end
      checks++;
      if (nls != 1) begin failures++; $display("FAIL clean_ls_count got=%0d exp=1", nls); end
      checks++;
      if (nhb != 64) begin failures++; $display("FAIL clean_hblank_len got=%0d exp=64", nhb); end
      checks++;
      if (nhs != 24) begin failures++; $display("FAIL clean_hsync_len got=%0d exp=24", nhs); end
      chk_err("clean_err", 8'd0);
   endtask

   task automatic test_midline();
      int bad;
      spos = 128; do_reset(); spos = 128;
      bad = 0;
      for (int i = 0; i < 192; i++) begin
         pos_step();
         if (bus.locked !== 1'b0 || bus.hblank !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL midline_unlocked bad_cycles=%0d exp=0", bad); end
      run_to(834); chk_lock("midline_pre_lock", 1'b0);
      run(1);      chk_lock("midline_lock", 1'b1);
   endtask

   task automatic test_glitch();
      lock_up();
      while (spos != 100) pos_step();
      step(1'b0, 8'h12); spos = 101;
      run(4);
      chk_err("glitch_err", 8'd1);
      chk_lock("glitch_locked", 1'b1);
      while (spos != 2) pos_step();
      checks++;
      if (bus.line_start !== 1'b0) begin failures++; $display("FAIL glitch_ls_early got=1 exp=0"); end
      pos_step();
      checks++;
      if (bus.line_start !== 1'b1) begin failures++; $display("FAIL glitch_ls_phase got=0 exp=1"); end
   endtask

   task automatic test_shift();
      int k0;
      lock_up();
      while (spos != 200) pos_step();
      spos = 205;
      run(10);
      chk_lock("shift_drop", 1'b0);
      chk_err("shift_err", 8'd3);
      while (spos != 0) pos_step();
      k0 = k + 1;
      run_to(k0 + 641); chk_lock("shift_pre_relock", 1'b0);
      run(1);           chk_lock("shift_relock", 1'b1);
      chk_err("shift_err_final", 8'd3);
   endtask

   task automatic test_illegal();
      spos = 0; do_reset(); spos = 0;
      run(51);
      step(1'b1, 8'h80); spos = 52;
      run(3);
      chk_err("illegal_err", 8'd1);
      chk_lock("illegal_unlocked", 1'b0);
      run_to(643); chk_lock("illegal_no_old_lock", 1'b0);
      run_to(962); chk_lock("illegal_pre_relock", 1'b0);
      run(1);      chk_lock("illegal_relock", 1'b1);
   endtask

   task automatic test_reset_mid();
      int k0;
      lock_up();
      while (spos != 100) pos_step();
      step(1'b0, 8'h12); spos = 101;
      run(5);
      chk_err("rstmid_pre_err", 8'd1);
      do_reset();
      chk_reset_vals("rstmid_vals");
      while (spos != 0) pos_step();
      k0 = k + 1;
      run_to(k0 + 641); chk_lock("rstmid_pre_relock", 1'b0);
      run(1);           chk_lock("rstmid_relock", 1'b1);
   endtask

   // Two bad samples then one good keeps the miss counter below its limit.
   task automatic test_saturation();
      lock_up();
      for (int g = 0; g < 130; g++) begin
         step(1'b1, 8'h80); spos = (spos + 1) % 320;
         step(1'b1, 8'h80); spos = (spos + 1) % 320;
         pos_step();
      end
      run(3);
      chk_err("sat_err", 8'hFF);
      chk_lock("sat_locked", 1'b1);
   endtask

   initial begin
      bus.h8 = 1'b0; bus.hcnt = 8'd0;
      @(negedge clk);
      test_reset();
      test_clean();
      test_midline();
      test_glitch();
      test_shift();
      test_illegal();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hcnt_timing_decoder.md
# hcnt_timing_decoder

Receive side of the horizontal counter interface. It samples the 8-bit horizontal count and the H8 phase bit produced by the H8-feedback horizontal counter, and checks that they follow the legal line sequence. A flywheel keeps a local copy of the line position, and the block drives registered HBLANK, HSYNC and line-start strobes from that copy to the video and vertical-count logic. It also tracks lock state and counts sequence errors.

## Interface
- `LOAD_VAL`, 8'hC0: counter reload value; first count of the H8=1 segment.
- `HBL_START`, 0: linear position where HBLANK asserts (inclusive).
- `HBL_END`, 64: linear position where HBLANK deasserts (exclusive).
- `HS_START`, 16: linear position where HSYNC asserts (inclusive).
- `HS_END`, 40: linear position where HSYNC deasserts (exclusive).
- `LOCK_LINES`, 2: number of consecutive clean lines required to declare lock.
- `MAX_MISS`, 3: number of consecutive mismatches while locked before lock is dropped.
- `clk` in 1: master pixel clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `hcnt` in 8: horizontal count from the generator.
- `h8` in 1: H8 phase bit from the generator.
- `hblank` out 1: horizontal blank, registered.
- `hsync` out 1: horizontal sync, active-high, registered.
- `line_start` out 1: one-clock pulse at flywheel position 0.
- `locked` out 1: flywheel is locked to the input.
- `err_cnt` out 8: sequence error count; saturates at 8'hFF.

## Operation
- Legal input sequence: h8=1 with hcnt LOAD_VAL..8'hFF, then h8=0 with hcnt 8'h00..8'hFF, then repeat. This gives LINE_LEN = 256 + (256 − LOAD_VAL) = 320 clocks at default.
- Linear position of the input:
  - when h8=1: in_pos = hcnt − LOAD_VAL;
  - when h8=0: in_pos = hcnt + (256 − LOAD_VAL).
  - in_pos is 9 bits wide, range 0..LINE_LEN−1.
- When h8=1 and hcnt < LOAD_VAL the input is illegal: in_pos_valid=0.
- Stage 1: register hcnt and h8, then compute in_pos and in_pos_valid.
- Flywheel fly_pos (9 bits): increments every clock and wraps from LINE_LEN−1 to 0.
- Lock FSM states:
  - UNLOCKED: locked=0. When in_pos_valid and in_pos==0, load fly_pos←0 and go to TRACK with line counter = 0.
  - TRACK: locked=0.
    - Any cycle with !in_pos_valid or in_pos≠fly_pos: go to UNLOCKED and increment err_cnt.
    - When fly_pos wraps to 0: increment the line counter. When it reaches LOCK_LINES, go to LOCKED.
  - LOCKED: locked=1.
    - Mismatch: increment err_cnt and the miss counter, and keep flywheeling (no reload).
    - Match: clear the miss counter.
    - When the miss counter reaches MAX_MISS: go to UNLOCKED.
- Output decode from fly_pos, gated by the state:
  - hblank = (HBL_START ≤ fly_pos < HBL_END);
  - hsync = (HS_START ≤ fly_pos < HS_END);
  - line_start = (fly_pos == 0).
  - In UNLOCKED and TRACK: hblank=1, hsync=0, line_start=0.
- err_cnt saturates at 8'hFF and is cleared only by rst.
- Simultaneous events:
  - A mismatch that coincides with a TRACK line-count completion wins: the FSM goes to UNLOCKED, not LOCKED.
  - In UNLOCKED, a valid in_pos==0 re-acquires in that same cycle.

## Timing
- Reset values: hblank=1, hsync=0, line_start=0, locked=0, err_cnt=0; FSM=UNLOCKED; fly_pos=0; all counters 0.
- rst asserted mid-line: all state and outputs take their reset values on the next edge. No partial line is counted.
- Latency: an input sampled at edge N is compared at edge N+1. Outputs for the corresponding fly_pos are registered at edge N+2, so outputs trail the input by 2 clocks.
- The locked transition becomes visible on the same edge as the first output decode of the new line.
- The generator presents a new hcnt/h8 every clock. There is no handshake; clock enables are external to this block.

## Test plan
- **Clean stream:** reset, then drive the legal 320-clock sequence starting at hcnt=C0, h8=1. Required:
  - locked=1 after 2 full lines plus 2 clocks;
  - line_start once per 320 clocks;
  - hblank high for 64 clocks and hsync high for clocks 16..39 of each line;
  - err_cnt=0.
- **Mid-line start:** start the stream at hcnt=8'h40, h8=0. Required: stays UNLOCKED with hblank=1 until the first C0/h8=1 sample, then locks normally.
- **Single glitch while locked:** replace one sample with hcnt=8'h12. Required:
  - err_cnt=1 and locked stays 1;
  - outputs keep flywheel timing with no phase shift.
- **Persistent misalignment:** shift the stream by 5 clocks while locked. Required:
  - locked drops after 3 mismatches and err_cnt=3;
  - re-lock to the new phase after 2 clean lines.
- **Illegal value:** h8=1 with hcnt=8'h80 during TRACK. Required: return to UNLOCKED and err_cnt increments.
- **Reset mid-operation:** assert rst for 1 clock while locked mid-line. Required: all outputs at reset values on the next edge, err_cnt=0, then a full re-acquire.
